// File: rtl/serial_adder.sv
// serial_adder -- bit-serial ripple adder, one bit per clock, LSB first.
//
// A request on start (sampled in IDLE) captures a, b and cin. The block then
// spends WIDTH cycles in RUN, handling one bit per cycle with two half-adder
// cells plus an OR. The final edge of RUN registers sum and cout. done then
// pulses for one cycle in DONE, and the block returns to IDLE.
//
// State table
//   state | meaning
//   IDLE  | waiting for start; sum/cout hold the last result
//   RUN   | processing one operand bit per cycle (busy=1)
//   DONE  | one-cycle done pulse; result valid on sum/cout
//
// Ports
//   clk    in   single clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   request one addition (honoured in IDLE only)
//   a, b   in   WIDTH-bit operands
//   cin    in   carry-in
//   busy   out  high while in RUN
//   done   out  one-cycle pulse marking a valid result
//   sum    out  registered WIDTH-bit sum
//   cout   out  registered carry-out
`timescale 1ns/1ps
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] s_sr;
  logic             c_q;
  logic [CW-1:0]    cnt;

  logic capture;
  logic step;
  logic last;

  logic ha0_s, ha0_c, ha1_c;
  logic bit_s, bit_c;
  logic [WIDTH-1:0] s_next;

  // Two half adders plus an OR form the full-adder cell.
  assign ha0_s  = a_sr[0] ^ b_sr[0];
  assign ha0_c  = a_sr[0] & b_sr[0];
  assign bit_s  = ha0_s ^ c_q;
  assign ha1_c  = ha0_s & c_q;
  assign bit_c  = ha0_c | ha1_c;

  // The new sum bit enters at the MSB. After WIDTH shifts, bit 0 of the
  // result sits at the LSB.
  assign s_next = {bit_s, s_sr[WIDTH-1:1]};
  assign last   = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    capture  = 1'b0;
    step     = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          capture  = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (last) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr <= '0;
      b_sr <= '0;
      s_sr <= '0;
      c_q  <= 1'b0;
      cnt  <= '0;
      sum  <= '0;
      cout <= 1'b0;
    end else if (capture) begin
      a_sr <= a;
      b_sr <= b;
      s_sr <= '0;
      c_q  <= cin;
      cnt  <= '0;
    end else if (step) begin
      a_sr <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr <= {1'b0, b_sr[WIDTH-1:1]};
      s_sr <= s_next;
      c_q  <= bit_c;
      cnt  <= cnt + CW'(1);
      if (last) begin
        sum  <= s_next;
        cout <= bit_c;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
`timescale 1ns/1ps
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int n_vec  = 0;
  int n_miss = 0;

  logic [W-1:0] prev_sum;
  logic         prev_cout;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  vec_t vecs[10];

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs one addition with a one-cycle start pulse. Operands are scrambled
  // right after capture. The task checks the latency, the busy length, the
  // result, the hold of the previous result during RUN, and the single-cycle
  // done pulse.
  task automatic run_op(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vc, input logic [W-1:0] es, input logic ec);
    int lat;
    int busy_cnt;
    a = va; b = vb; cin = vc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~va; b = va ^ vb; cin = ~vc;
    check({name, " hold_sum"}, 32'(sum), 32'(prev_sum));
    check({name, " hold_cout"}, 32'(cout), 32'(prev_cout));
    lat = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (busy) busy_cnt++;
    end
    check({name, " latency"}, 32'(lat), 32'(W));
    check({name, " busy_cycles"}, 32'(busy_cnt), 32'(W));
    check({name, " sum"}, 32'(sum), 32'(es));
    check({name, " cout"}, 32'(cout), 32'(ec));
    @(negedge clk);
    check({name, " done_one_cycle"}, 32'(done), 32'd0);
    prev_sum  = es;
    prev_cout = ec;
  endtask

  initial begin
    vecs[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
    vecs[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    vecs[8] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vecs[9] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0};

    prev_sum = '0;
    prev_cout = 1'b0;

    // Hold reset with start asserted and random operands.
    rst_n = 1'b0; start = 1'b1; cin = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = W'($urandom); b = W'($urandom);
      @(negedge clk);
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset sum", 32'(sum), 32'd0);
      check("reset cout", 32'(cout), 32'd0);
    end
    start = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout);
    end

    // A start request in the 3rd RUN cycle is dropped.
    begin
      int lat;
      int extra;
      a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      a = 8'hAA; b = 8'h55; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 3;
      while (!done && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      check("ignore latency", 32'(lat), 32'(W));
      check("ignore sum", 32'(sum), 32'h30);
      check("ignore cout", 32'(cout), 32'd0);
      extra = 0;
      for (int i = 0; i < 15; i++) begin
        @(negedge clk);
        if (done || busy) extra++;
      end
      check("ignore no second op", 32'(extra), 32'd0);
      prev_sum = 8'h30; prev_cout = 1'b0;
    end

    // A reset in the 4th RUN cycle aborts the operation at once.
    begin
      int dones;
      a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort busy", 32'(busy), 32'd0);
      check("abort done", 32'(done), 32'd0);
      check("abort sum", 32'(sum), 32'd0);
      check("abort cout", 32'(cout), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (done) dones++;
      end
      check("abort no done", 32'(dones), 32'd0);
      prev_sum = '0; prev_cout = 1'b0;
      run_op("after_abort", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0);
    end

    // With start held high, operations run back to back every W+2 cycles.
    begin
      int gap;
      a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
      gap = 0;
      while (!done && gap < 20) begin
        @(negedge clk);
        gap++;
      end
      check("b2b first sum", 32'(sum), 32'h03);
      a = 8'h05; b = 8'h06;
      gap = 0;
      do begin
        @(negedge clk);
        gap++;
      end while (!done && gap < 30);
      check("b2b period", 32'(gap), 32'(W + 2));
      check("b2b second sum", 32'(sum), 32'h0B);
      start = 1'b0;
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH SHALL default to 8 and set the operand and sum width; the legal range is 2..32.
REQ-002 Port clk SHALL be an input, 1 bit wide, and be the single clock; all state changes on its rising edge.
REQ-003 Port rst_n SHALL be an input, 1 bit wide, and be the reset: asynchronous, active-low.
REQ-004 Port start SHALL be an input, 1 bit wide, and request one addition; it is sampled on the rising edge.
REQ-005 Port a SHALL be an input, WIDTH bits wide, and carry operand A.
REQ-006 Port b SHALL be an input, WIDTH bits wide, and carry operand B.
REQ-007 Port cin SHALL be an input, 1 bit wide, and carry the carry-in.
REQ-008 Port busy SHALL be an output, 1 bit wide, driven high while bits are being processed.
REQ-009 Port done SHALL be an output, 1 bit wide, driven as a one-cycle pulse that marks a valid result.
REQ-010 Port sum SHALL be an output, WIDTH bits wide, and carry the registered result sum.
REQ-011 Port cout SHALL be an output, 1 bit wide, and carry the registered result carry-out.

Function
REQ-012 The block SHALL implement a state machine with states IDLE, RUN and DONE.
REQ-013 In IDLE, an edge with start=1 SHALL capture a, b and cin into internal registers A, B and C, clear the bit counter, and move the state to RUN.
REQ-014 Each RUN edge SHALL compute s=A[0]^B[0]^C and c=(A[0]&B[0])|(C&(A[0]^B[0])), formed as two half-adder cells plus an OR.
REQ-015 On the same RUN edge, s SHALL shift into the MSB of the internal sum shift register, A and B SHALL shift right by one, C SHALL load c, and the counter SHALL increment.
REQ-016 RUN SHALL last exactly WIDTH cycles; the edge that processes bit WIDTH-1 SHALL load sum and cout from the final shift-register value and final carry, and move the state to DONE.
REQ-017 Latency: done SHALL rise on the WIDTH-th rising edge after the edge that sampled start, which is 8 edges for WIDTH=8.
REQ-018 done SHALL be high for exactly one cycle, in state DONE; the next edge SHALL return the state to IDLE unconditionally.
REQ-019 busy SHALL be 1 exactly while the state is RUN and 0 in IDLE and DONE.
REQ-020 Arithmetic: {cout,sum} SHALL equal a+b+cin, computed on the captured values, modulo 2^(WIDTH+1).
REQ-021 sum and cout SHALL change only on the completion edge and SHALL otherwise hold their value through IDLE and the following RUN.
REQ-022 start SHALL be ignored in RUN and DONE; no queuing, and the in-flight operation SHALL be unaffected.
REQ-023 Changes on a, b or cin after the capture edge SHALL have no effect on the current operation.
REQ-024 start held high continuously SHALL start a new operation on each IDLE edge, giving back-to-back operations with a period of WIDTH+2 cycles.

Reset
REQ-025 rst_n=0 SHALL immediately and asynchronously force state=IDLE, busy=0, done=0, sum=0, cout=0, and clear A, B, C and the counter.
REQ-026 Assertion of rst_n mid-RUN SHALL abort the operation; no done pulse SHALL be produced for the aborted operation.
REQ-027 After rst_n deasserts, the first rising edge SHALL be able to accept start.

Verification (WIDTH=8)
REQ-028 Reset: hold rst_n=0 with start=1 and random a and b -> busy=0, done=0, sum=8'h00, cout=0 throughout.
REQ-029 Basic add: a=8'h35, b=8'h4A, cin=0, start pulsed for one cycle -> busy high for 8 cycles, done on the 8th edge, sum=8'h7F, cout=0.
REQ-030 Full carry ripple: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1.
REQ-031 Maximum value: a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
REQ-032 Start ignored while busy: start a=8'h10, b=8'h20, then pulse start with a=8'hAA, b=8'h55 at the 3rd RUN cycle -> single done pulse, sum=8'h30; the second request is dropped.
REQ-033 Reset mid-operation: pull rst_n low during the 4th RUN cycle -> outputs clear at once and no done pulse; after release, start a=8'h12, b=8'h34, cin=1 -> sum=8'h47, cout=0.
